toy_cpu_sequencer: RTL and testbench

//  Run controller for the 4-bit toy CPU (PC, A/B/OUT regs, carry DFF, 16x8 program memory).

---
 rtl/toy_cpu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_toy_cpu_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_cpu_sequencer.sv
// Run controller for the 4-bit toy CPU: issues one datapath clock-enable per
// instruction slot, owns the program memory port while loading, and stops the
// run on a self-jump, an instruction budget or a host HALT.
module toy_cpu_sequencer #(
    parameter int STRIDE   = 2,    // cycles per instruction slot (2..16)
    parameter int MAX_INSN = 255,  // instruction budget per RUN
    parameter int CNT_W    = 8     // width of insn_cnt, MAX_INSN < 2**CNT_W
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             wr_valid,
    input  logic [3:0]       wr_ad,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic [3:0]       pc,
    input  logic [3:0]       op,
    input  logic [3:0]       im,
    output logic             ce,
    output logic             pc_clr,
    output logic             mem_sel,
    output logic             mem_we,
    output logic [3:0]       mem_ad,
    output logic [7:0]       mem_wd,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] insn_cnt
);

    localparam int SLOT_W = (STRIDE > 2) ? $clog2(STRIDE) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(STRIDE - 1);
    localparam logic [CNT_W-1:0]  BUDGET    = CNT_W'(MAX_INSN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_LOAD} state_e;
    typedef enum logic [1:0] {CMD_RUN = 2'd0, CMD_STEP = 2'd1,
                              CMD_HALT = 2'd2, CMD_LOAD = 2'd3} cmd_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [3:0]          wr_cnt_q, wr_cnt_d;
    logic                load_done_q, load_done_d;

    logic                ce_d, pc_clr_d, mem_we_d, halted_d, timeout_d;
    logic [3:0]          mem_ad_d;
    logic [7:0]          mem_wd_d;
    logic [CNT_W-1:0]    insn_cnt_d;

    cmd_e                cmd_c;
    logic                cmd_acc, wr_acc, self_jump, budget_hit;

    assign cmd_c      = cmd_e'(cmd);
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign wr_acc     = wr_valid && wr_ready;
    assign self_jump  = (op == 4'b1111) && (im == pc);
    assign budget_hit = (insn_cnt == BUDGET);

    // Next-state and next-output decode for the run/step/load controller.
    // NOTE: every variable gets its default before the case statement so no
    // path through the block leaves one unassigned and a latch is never inferred.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        wr_cnt_d    = wr_cnt_q;
        load_done_d = load_done_q;
        ce_d        = 1'b0;
        pc_clr_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_ad_d    = mem_ad;
        mem_wd_d    = mem_wd;
        halted_d    = halted;
        timeout_d   = timeout;
        insn_cnt_d  = insn_cnt;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    unique case (cmd_c)
                        CMD_RUN: begin
                            state_d    = S_RUN;
                            slot_d     = '0;
                            insn_cnt_d = '0;
                            halted_d   = 1'b0;
                            timeout_d  = 1'b0;
                        end
                        CMD_STEP: begin
                            state_d = S_STEP;
                            slot_d  = '0;
                        end
                        CMD_LOAD: begin
                            state_d     = S_LOAD;
                            wr_cnt_d    = '0;
                            load_done_d = 1'b0;
                        end
                        default: ;  // HALT while idle is a no-op
                    endcase
                end
            end

            S_RUN, S_STEP: begin
                if (state_q == S_RUN && cmd_acc && cmd_c == CMD_HALT) begin
                    // Host stop wins over the slot-0 test: no CE, no flag.
                    state_d = S_IDLE;
                end else if (slot_q == '0) begin
                    if (self_jump || budget_hit) begin
                        halted_d  = halted  | self_jump;
                        timeout_d = timeout | budget_hit;
                        state_d   = S_IDLE;
                    end else begin
                        ce_d       = 1'b1;
                        insn_cnt_d = (insn_cnt == '1) ? insn_cnt : insn_cnt + CNT_W'(1);
                        slot_d     = SLOT_W'(1);
                    end
                end else if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (state_q == S_STEP) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end

            S_LOAD: begin
                if (!load_done_q) begin
                    if (wr_acc) begin
                        mem_we_d = 1'b1;
                        mem_ad_d = wr_ad;
                        mem_wd_d = wr_data;
                        wr_cnt_d = wr_cnt_q + 4'd1;
                    end
                    // Stay one more cycle so the last captured word is written
                    // while the memory port still belongs to the loader.
                    if ((wr_acc && wr_cnt_q == 4'd15) || (cmd_acc && cmd_c == CMD_HALT)) begin
                        load_done_d = 1'b1;
                    end
                end else begin
                    state_d     = S_IDLE;
                    load_done_d = 1'b0;
                    pc_clr_d    = 1'b1;
                    insn_cnt_d  = '0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any run or pending write.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            wr_cnt_q    <= '0;
            load_done_q <= 1'b0;
            cmd_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            ce          <= 1'b0;
            pc_clr      <= 1'b1;
            mem_sel     <= 1'b0;
            mem_we      <= 1'b0;
            mem_ad      <= '0;
            mem_wd      <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            insn_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            wr_cnt_q    <= wr_cnt_d;
            load_done_q <= load_done_d;
            cmd_ready   <= (state_d != S_STEP);
            wr_ready    <= (state_d == S_LOAD) && !load_done_d;
            ce          <= ce_d;
            pc_clr      <= pc_clr_d;
            mem_sel     <= (state_d == S_LOAD);
            mem_we      <= mem_we_d;
            mem_ad      <= mem_ad_d;
            mem_wd      <= mem_wd_d;
            busy        <= (state_d != S_IDLE);
            halted      <= halted_d;
            timeout     <= timeout_d;
            insn_cnt    <= insn_cnt_d;
        end
    end

endmodule

// File: tb/tb_toy_cpu_sequencer.sv
// Directed bench for toy_cpu_sequencer: two instances share host stimulus,
// dut_a with the default budget and dut_b with a budget of 3. Each has a small
// stand-in datapath (PC + 16x8 program memory, opcode F = JMP IM).
module tb_toy_cpu_sequencer;

    localparam logic [1:0] C_RUN = 2'd0, C_STEP = 2'd1, C_HALT = 2'd2, C_LOAD = 2'd3;

    logic       ck;
    logic       rst_n, cmd_valid, wr_valid;
    logic [1:0] cmd;
    logic [3:0] wr_ad;
    logic [7:0] wr_data;

    logic       cmd_ready_a, wr_ready_a, ce_a, pc_clr_a, mem_sel_a, mem_we_a, busy_a, halted_a, timeout_a;
    logic [3:0] mem_ad_a, pc_a, op_a, im_a;
    logic [7:0] mem_wd_a, insn_cnt_a;
    logic       cmd_ready_b, wr_ready_b, ce_b, pc_clr_b, mem_sel_b, mem_we_b, busy_b, halted_b, timeout_b;
    logic [3:0] mem_ad_b, pc_b, op_b, im_b;
    logic [7:0] mem_wd_b, insn_cnt_b;

    logic [7:0] pmem_a [16];
    logic [7:0] pmem_b [16];
    logic [7:0] prog   [16];

    int vectors    = 0;
    int miscompares = 0;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    toy_cpu_sequencer dut_a (
        .ck(ck), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready_a),
        .wr_valid(wr_valid), .wr_ad(wr_ad), .wr_data(wr_data), .wr_ready(wr_ready_a),
        .pc(pc_a), .op(op_a), .im(im_a), .ce(ce_a), .pc_clr(pc_clr_a), .mem_sel(mem_sel_a),
        .mem_we(mem_we_a), .mem_ad(mem_ad_a), .mem_wd(mem_wd_a), .busy(busy_a),
        .halted(halted_a), .timeout(timeout_a), .insn_cnt(insn_cnt_a)
    );

    toy_cpu_sequencer #(.STRIDE(2), .MAX_INSN(3), .CNT_W(8)) dut_b (
        .ck(ck), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready_b),
        .wr_valid(wr_valid), .wr_ad(wr_ad), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .pc(pc_b), .op(op_b), .im(im_b), .ce(ce_b), .pc_clr(pc_clr_b), .mem_sel(mem_sel_b),
        .mem_we(mem_we_b), .mem_ad(mem_ad_b), .mem_wd(mem_wd_b), .busy(busy_b),
        .halted(halted_b), .timeout(timeout_b), .insn_cnt(insn_cnt_b)
    );

    // Stand-in datapath for dut_a: memory write port, PC advance/jump on CE.
    always @(posedge ck) begin
        if (mem_we_a) pmem_a[mem_ad_a] <= mem_wd_a;
        if (pc_clr_a)  pc_a <= 4'd0;
        else if (ce_a) pc_a <= (op_a == 4'hF) ? im_a : pc_a + 4'd1;
    end
    assign {op_a, im_a} = pmem_a[pc_a];

    // Stand-in datapath for dut_b.
    always @(posedge ck) begin
        if (mem_we_b) pmem_b[mem_ad_b] <= mem_wd_b;
        if (pc_clr_b)  pc_b <= 4'd0;
        else if (ce_b) pc_b <= (op_b == 4'hF) ? im_b : pc_b + 4'd1;
    end
    assign {op_b, im_b} = pmem_b[pc_b];

    task automatic tick();
        @(negedge ck);
    endtask

    // Present a command and hold it until the edge that accepts it.
    task automatic send_cmd(input logic [1:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd = c;
        while (!cmd_ready_a && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (cmd_ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b after 20 cycles, required 1", cmd_ready_a);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_a && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_wait: busy=%b after 50 cycles, required 0", busy_a);
        end
    endtask

    // Load prog[0..n-1]; fewer than 16 words are terminated with HALT.
    task automatic load_prog(input int n);
        send_cmd(C_LOAD);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_ad    = 4'(i);
            wr_data  = prog[i];
            tick();
        end
        wr_valid = 1'b0;
        if (n < 16) send_cmd(C_HALT);
        wait_idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = C_RUN;
        wr_valid = 1'b0; wr_ad = 4'd0; wr_data = 8'd0;
        repeat (3) tick();
        vectors++;
        if ({pc_clr_a, ce_a, busy_a, cmd_ready_a, wr_ready_a, mem_sel_a, mem_we_a, halted_a, timeout_a,
             mem_ad_a, mem_wd_a, insn_cnt_a} !== {1'b1, 8'b0, 4'h0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs_a: pc_clr=%b ce=%b busy=%b rdy=%b wrdy=%b sel=%b we=%b h=%b t=%b ad=%h wd=%h cnt=%0d, required pc_clr=1 rest 0",
                     pc_clr_a, ce_a, busy_a, cmd_ready_a, wr_ready_a, mem_sel_a, mem_we_a, halted_a, timeout_a,
                     mem_ad_a, mem_wd_a, insn_cnt_a);
        end
        vectors++;
        if ({pc_clr_b, ce_b, busy_b, cmd_ready_b, wr_ready_b, mem_sel_b, mem_we_b, halted_b, timeout_b,
             mem_ad_b, mem_wd_b, insn_cnt_b} !== {1'b1, 8'b0, 4'h0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs_b: pc_clr=%b ce=%b busy=%b rdy=%b, required pc_clr=1 rest 0",
                     pc_clr_b, ce_b, busy_b, cmd_ready_b);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({pc_clr_a, cmd_ready_a, busy_a} !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_release: pc_clr=%b cmd_ready=%b busy=%b, required 0 1 0",
                     pc_clr_a, cmd_ready_a, busy_a);
        end
    endtask

    task automatic test_load_back_to_back();
        logic [7:0] d;
        logic       rdy;
        send_cmd(C_LOAD);
        vectors++;
        if ({wr_ready_a, mem_sel_a, busy_a, mem_we_a, ce_a} !== 5'b11100) begin
            miscompares++;
            $display("FAIL load_entry: wr_ready=%b mem_sel=%b busy=%b mem_we=%b ce=%b, required 1 1 1 0 0",
                     wr_ready_a, mem_sel_a, busy_a, mem_we_a, ce_a);
        end
        for (int i = 0; i < 16; i++) begin
            d        = {4'(i), 4'(15 - i)};
            rdy      = (i < 15);
            wr_valid = 1'b1;
            wr_ad    = 4'(i);
            wr_data  = d;
            tick();
            vectors++;
            if ({mem_we_a, mem_ad_a, mem_wd_a, wr_ready_a, mem_sel_a} !== {1'b1, 4'(i), d, rdy, 1'b1}) begin
                miscompares++;
                $display("FAIL load_write_%0d: we=%b ad=%h wd=%h wr_ready=%b sel=%b, required 1 %h %h %b 1",
                         i, mem_we_a, mem_ad_a, mem_wd_a, wr_ready_a, mem_sel_a, 4'(i), d, rdy);
            end
        end
        wr_valid = 1'b0;
        tick();
        vectors++;
        if ({mem_we_a, mem_sel_a, pc_clr_a, busy_a, wr_ready_a, insn_cnt_a} !== {5'b00100, 8'd0}) begin
            miscompares++;
            $display("FAIL load_exit: we=%b sel=%b pc_clr=%b busy=%b wr_ready=%b cnt=%0d, required 0 0 1 0 0 0",
                     mem_we_a, mem_sel_a, pc_clr_a, busy_a, wr_ready_a, insn_cnt_a);
        end
        tick();
        vectors++;
        if (pc_clr_a !== 1'b0) begin
            miscompares++;
            $display("FAIL load_pc_clr_pulse: pc_clr=%b one cycle later, required 0", pc_clr_a);
        end
    endtask

    task automatic set_five_word_prog();
        prog[0] = 8'h01; prog[1] = 8'h12; prog[2] = 8'h23; prog[3] = 8'h34; prog[4] = 8'hF4;
    endtask

    task automatic test_run_to_self_jump();
        logic exp_ce, exp_busy;
        set_five_word_prog();
        load_prog(5);
        send_cmd(C_RUN);
        for (int i = 0; i < 10; i++) begin
            exp_ce   = (i < 8) && (i % 2 == 1);
            exp_busy = (i <= 8);
            vectors++;
            if ({ce_a, busy_a} !== {exp_ce, exp_busy}) begin
                miscompares++;
                $display("FAIL run_cycle_%0d: ce=%b busy=%b, required %b %b", i, ce_a, busy_a, exp_ce, exp_busy);
            end
            tick();
        end
        vectors++;
        if ({halted_a, timeout_a, insn_cnt_a} !== {2'b10, 8'd4}) begin
            miscompares++;
            $display("FAIL run_self_jump_end: halted=%b timeout=%b cnt=%0d, required 1 0 4",
                     halted_a, timeout_a, insn_cnt_a);
        end
    endtask

    task automatic test_halt_mid_run();
        int n_ce;
        n_ce = 0;
        set_five_word_prog();
        load_prog(5);
        send_cmd(C_RUN);
        for (int i = 0; i < 8; i++) begin
            if (ce_a) n_ce++;
            if (i == 4) begin
                vectors++;
                if (cmd_ready_a !== 1'b1) begin
                    miscompares++;
                    $display("FAIL halt_ready_in_run: cmd_ready=%b, required 1", cmd_ready_a);
                end
                cmd_valid = 1'b1;
                cmd       = C_HALT;
            end
            if (i == 5) cmd_valid = 1'b0;
            tick();
        end
        vectors++;
        if (n_ce !== 2) begin
            miscompares++;
            $display("FAIL halt_ce_count: %0d CE pulses, required 2", n_ce);
        end
        vectors++;
        if ({halted_a, timeout_a, busy_a, insn_cnt_a} !== {3'b000, 8'd2}) begin
            miscompares++;
            $display("FAIL halt_end_state: halted=%b timeout=%b busy=%b cnt=%0d, required 0 0 0 2",
                     halted_a, timeout_a, busy_a, insn_cnt_a);
        end
    endtask

    task automatic test_self_jump_at_start();
        int n_ce;
        n_ce = 0;
        prog[0] = 8'hF0;
        load_prog(1);
        send_cmd(C_RUN);
        vectors++;
        if ({busy_a, ce_a} !== 2'b10) begin
            miscompares++;
            $display("FAIL jmp0_first_cycle: busy=%b ce=%b, required 1 0", busy_a, ce_a);
        end
        for (int i = 0; i < 6; i++) begin
            if (ce_a) n_ce++;
            tick();
        end
        vectors++;
        if ({n_ce[3:0], busy_a, halted_a, timeout_a, insn_cnt_a} !== {4'd0, 3'b010, 8'd0}) begin
            miscompares++;
            $display("FAIL jmp0_end: ce_pulses=%0d busy=%b halted=%b timeout=%b cnt=%0d, required 0 0 1 0 0",
                     n_ce, busy_a, halted_a, timeout_a, insn_cnt_a);
        end
    endtask

    task automatic test_budget_timeout();
        int n_ce;
        n_ce = 0;
        prog[0] = 8'h01; prog[1] = 8'hF0;
        load_prog(2);
        send_cmd(C_RUN);
        for (int i = 0; i < 10; i++) begin
            if (ce_b) n_ce++;
            tick();
        end
        vectors++;
        if (n_ce !== 3) begin
            miscompares++;
            $display("FAIL budget_ce_count: %0d CE pulses, required 3", n_ce);
        end
        vectors++;
        if ({timeout_b, halted_b, busy_b, insn_cnt_b} !== {3'b100, 8'd3}) begin
            miscompares++;
            $display("FAIL budget_end: timeout=%b halted=%b busy=%b cnt=%0d, required 1 0 0 3",
                     timeout_b, halted_b, busy_b, insn_cnt_b);
        end
        vectors++;
        if (busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL budget_large_still_running: busy=%b, required 1", busy_a);
        end
        send_cmd(C_HALT);
        wait_idle();
        vectors++;
        if ({halted_a, timeout_a, timeout_b} !== 3'b001) begin
            miscompares++;
            $display("FAIL budget_after_halt: halted_a=%b timeout_a=%b timeout_b=%b, required 0 0 1",
                     halted_a, timeout_a, timeout_b);
        end
    endtask

    task automatic test_step();
        set_five_word_prog();
        load_prog(5);
        for (int k = 1; k <= 2; k++) begin
            send_cmd(C_STEP);
            vectors++;
            if ({cmd_ready_a, busy_a, ce_a} !== 3'b010) begin
                miscompares++;
                $display("FAIL step%0d_enter: cmd_ready=%b busy=%b ce=%b, required 0 1 0",
                         k, cmd_ready_a, busy_a, ce_a);
            end
            tick();
            vectors++;
            if (ce_a !== 1'b1) begin
                miscompares++;
                $display("FAIL step%0d_ce: ce=%b, required 1", k, ce_a);
            end
            tick();
            vectors++;
            if ({cmd_ready_a, busy_a, ce_a, insn_cnt_a} !== {3'b100, 8'(k)}) begin
                miscompares++;
                $display("FAIL step%0d_done: cmd_ready=%b busy=%b ce=%b cnt=%0d, required 1 0 0 %0d",
                         k, cmd_ready_a, busy_a, ce_a, insn_cnt_a, k);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        send_cmd(C_LOAD);
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_ad    = 4'(i);
            wr_data  = 8'hA0 + 8'(i);
            tick();
        end
        wr_ad   = 4'd3;
        wr_data = 8'hA3;
        rst_n   = 1'b0;
        tick();
        vectors++;
        if ({mem_we_a, mem_sel_a, wr_ready_a, busy_a, ce_a, pc_clr_a, mem_we_b, pc_clr_b} !== 8'b00000101) begin
            miscompares++;
            $display("FAIL rst_mid_load: we=%b sel=%b wr_ready=%b busy=%b ce=%b pc_clr=%b we_b=%b pc_clr_b=%b, required 0 0 0 0 0 1 0 1",
                     mem_we_a, mem_sel_a, wr_ready_a, busy_a, ce_a, pc_clr_a, mem_we_b, pc_clr_b);
        end
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        vectors++;
        if ({pc_clr_a, busy_a, cmd_ready_a, mem_we_a} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_mid_load_release: pc_clr=%b busy=%b cmd_ready=%b we=%b, required 0 0 1 0",
                     pc_clr_a, busy_a, cmd_ready_a, mem_we_a);
        end
        vectors++;
        if (pmem_a[3] !== 8'h34) begin
            miscompares++;
            $display("FAIL rst_dropped_write: mem[3]=%h, required 34 (write after reset dropped)", pmem_a[3]);
        end
    endtask

    initial begin
        test_reset();
        test_load_back_to_back();
        test_run_to_self_jump();
        test_halt_mid_run();
        test_self_jump_at_start();
        test_budget_timeout();
        test_step();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
